// File: rtl/lt24_pixel_reader_pkg.sv
// Shared LT24 constants, FSM state encoding and address range helper
// for the LT24 single-pixel read controller.
package lt24_pixel_reader_pkg;

    localparam logic [15:0] LT24_CMD_CASET = 16'h002A;
    localparam logic [15:0] LT24_CMD_PASET = 16'h002B;
    localparam logic [15:0] LT24_CMD_RAMRD = 16'h002E;

    localparam int LT24_WIDTH  = 240;
    localparam int LT24_HEIGHT = 320;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CMD_COL   = 4'd1,
        DAT_COL   = 4'd2,
        CMD_PAGE  = 4'd3,
        DAT_PAGE  = 4'd4,
        CMD_RAMRD = 4'd5,
        TURN      = 4'd6,
        RD_DUMMY  = 4'd7,
        RD_RG     = 4'd8,
        RD_B      = 4'd9,
        DONE      = 4'd10
    } state_e;

    function automatic logic addr_in_range(input logic [7:0] x, input logic [8:0] y);
        return (int'(x) < LT24_WIDTH) && (int'(y) < LT24_HEIGHT);
    endfunction

endpackage

// File: rtl/lt24_pixel_reader_read_strobe.sv
// Rd_n phase generator: one read slot is LOW_CYCLES low then HIGH_CYCLES high,
// repeating while enabled; sample_o marks the last low cycle, done_o the last high cycle.
module lt24_read_strobe #(
    parameter int LOW_CYCLES  = 18,
    parameter int HIGH_CYCLES = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic rd_n_o,
    output logic sample_o,
    output logic done_o
);

    localparam int MAX_C = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);

    logic          low_q, low_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tc;

    assign tc = (cnt_q == '0);

    always_comb begin
        low_d = low_q;
        cnt_d = cnt_q;
        if (!en_i) begin
            low_d = 1'b1;
            cnt_d = LOW_LOAD;
        end else if (!tc) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            low_d = ~low_q;
            cnt_d = low_q ? HIGH_LOAD : LOW_LOAD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            low_q <= 1'b1;
            cnt_q <= LOW_LOAD;
        end else begin
            low_q <= low_d;
            cnt_q <= cnt_d;
        end
    end

    assign rd_n_o   = ~(en_i & low_q);
    assign sample_o = en_i & low_q & tc;
    assign done_o   = en_i & ~low_q & tc;

endmodule

// File: rtl/lt24_pixel_reader.sv
// Reads one RGB565 pixel from an LT24 panel: sets a 1x1 column/page window,
// issues the memory-read command, then performs dummy, R/G and B read slots.
//
// state     | meaning
// IDLE      | ready; out-of-range requests pulse error here
// CMD_COL   | column address command write slot
// DAT_COL   | four column address data slots
// CMD_PAGE  | page address command write slot
// DAT_PAGE  | four page address data slots
// CMD_RAMRD | memory read command write slot
// TURN      | pad turnaround, output enable dropped
// RD_DUMMY  | first read slot, data discarded
// RD_RG     | red/green read slot
// RD_B      | blue read slot
// DONE      | pixelValid pulse, CS_n released
module lt24_pixel_reader #(
    parameter int RD_LOW_CYCLES  = 18,
    parameter int RD_HIGH_CYCLES = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    output logic        ready,
    output logic [15:0] pixelData,
    output logic        pixelValid,
    output logic        error,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic [15:0] LT24DataOut,
    output logic        LT24DataOe,
    input  logic [15:0] LT24DataIn
);
    import lt24_pixel_reader_pkg::*;

    state_e      state_q, state_d;
    logic        wr_phase_q;
    logic [1:0]  wr_idx_q;
    logic [7:0]  x_q;
    logic [8:0]  y_q;
    logic [10:0] rg_q;
    logic [4:0]  b_q;
    logic [15:0] pixel_q;
    logic        error_q;

    logic accept, in_range, is_write, is_cmd, is_read, slot_end;
    logic rd_n, rd_sample, rd_done;
    logic unused_din;

    assign accept   = read & ready;
    assign in_range = addr_in_range(xAddr, yAddr);
    assign is_cmd   = (state_q == CMD_COL) || (state_q == CMD_PAGE) || (state_q == CMD_RAMRD);
    assign is_write = is_cmd || (state_q == DAT_COL) || (state_q == DAT_PAGE);
    assign is_read  = (state_q == RD_DUMMY) || (state_q == RD_RG) || (state_q == RD_B);
    assign slot_end = wr_phase_q && (is_cmd || (wr_idx_q == 2'd3));
    assign unused_din = ^{LT24DataIn[10:8], LT24DataIn[1:0]};

    lt24_read_strobe #(
        .LOW_CYCLES  (RD_LOW_CYCLES),
        .HIGH_CYCLES (RD_HIGH_CYCLES)
    ) u_read_strobe (
        .clk_i    (clock),
        .rst_i    (reset),
        .en_i     (is_read),
        .rd_n_o   (rd_n),
        .sample_o (rd_sample),
        .done_o   (rd_done)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept && in_range) state_d = CMD_COL;
            CMD_COL:   if (slot_end) state_d = DAT_COL;
            DAT_COL:   if (slot_end) state_d = CMD_PAGE;
            CMD_PAGE:  if (slot_end) state_d = DAT_PAGE;
            DAT_PAGE:  if (slot_end) state_d = CMD_RAMRD;
            CMD_RAMRD: if (slot_end) state_d = TURN;
            TURN:      state_d = RD_DUMMY;
            RD_DUMMY:  if (rd_done) state_d = RD_RG;
            RD_RG:     if (rd_done) state_d = RD_B;
            RD_B:      if (rd_done) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_phase_q <= 1'b0;
            wr_idx_q   <= 2'd0;
            x_q        <= 8'd0;
            y_q        <= 9'd0;
            rg_q       <= 11'd0;
            b_q        <= 5'd0;
            pixel_q    <= 16'd0;
            error_q    <= 1'b0;
        end else begin
            error_q <= accept && !in_range;
            if (accept && in_range) begin
                x_q <= xAddr;
                y_q <= yAddr;
            end
            if (is_write) begin
                wr_phase_q <= ~wr_phase_q;
                if (wr_phase_q) wr_idx_q <= slot_end ? 2'd0 : wr_idx_q + 2'd1;
            end else begin
                wr_phase_q <= 1'b0;
                wr_idx_q   <= 2'd0;
            end
            if (rd_sample && state_q == RD_RG) rg_q <= {LT24DataIn[15:11], LT24DataIn[7:2]};
            if (rd_sample && state_q == RD_B)  b_q  <= LT24DataIn[15:11];
            if (rd_done && state_q == RD_B)    pixel_q <= {rg_q, b_q};
        end
    end

    always_comb begin
        LT24CS_n    = 1'b1;
        LT24RS      = 1'b1;
        LT24Wr_n    = 1'b1;
        LT24Rd_n    = 1'b1;
        LT24DataOut = 16'h0000;
        LT24DataOe  = 1'b0;
        if (is_write) begin
            LT24CS_n   = 1'b0;
            LT24RS     = ~is_cmd;
            LT24Wr_n   = wr_phase_q;
            LT24DataOe = 1'b1;
            case (state_q)
                CMD_COL:  LT24DataOut = LT24_CMD_CASET;
                DAT_COL:  LT24DataOut = {8'h00, wr_idx_q[0] ? x_q : 8'h00};
                CMD_PAGE: LT24DataOut = LT24_CMD_PASET;
                DAT_PAGE: LT24DataOut = wr_idx_q[0] ? {8'h00, y_q[7:0]} : {15'h0000, y_q[8]};
                default:  LT24DataOut = LT24_CMD_RAMRD;
            endcase
        end else if (state_q == TURN) begin
            LT24CS_n = 1'b0;
        end else if (is_read) begin
            LT24CS_n = 1'b0;
            LT24Rd_n = rd_n;
        end
    end

    assign ready      = (state_q == IDLE);
    assign pixelValid = (state_q == DONE);
    assign pixelData  = pixel_q;
    assign error      = error_q;

endmodule

// File: tb/tb_lt24_pixel_reader.sv
// Self-checking bench for lt24_pixel_reader: directed and random pixel reads
// against a word/pixel reference model, with a bus protocol monitor throughout.
module tb_lt24_pixel_reader;

    localparam int RD_LOW  = 18;
    localparam int RD_HIGH = 5;
    localparam int LATENCY = 24 + 3 * (RD_LOW + RD_HIGH);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic [7:0]  xAddr = 8'd0;
    logic [8:0]  yAddr = 9'd0;
    logic [15:0] LT24DataIn = 16'h0000;
    logic        ready, pixelValid, error;
    logic [15:0] pixelData, LT24DataOut;
    logic        LT24CS_n, LT24RS, LT24Wr_n, LT24Rd_n, LT24DataOe;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [16:0] words[$];
    logic [15:0] pad[3];
    int rd_slot = 0, pv_cnt = 0, pv_cyc = 0, err_cnt = 0, err_cyc = 0, cs_starts = 0;
    int wr_run = 0, rd_run = 0;
    logic prev_cs_n = 1'b1, prev_rd_n = 1'b1;

    lt24_pixel_reader #(.RD_LOW_CYCLES(RD_LOW), .RD_HIGH_CYCLES(RD_HIGH)) dut (
        .clock       (clock),
        .reset       (reset),
        .read        (read),
        .xAddr       (xAddr),
        .yAddr       (yAddr),
        .ready       (ready),
        .pixelData   (pixelData),
        .pixelValid  (pixelValid),
        .error       (error),
        .LT24CS_n    (LT24CS_n),
        .LT24RS      (LT24RS),
        .LT24Wr_n    (LT24Wr_n),
        .LT24Rd_n    (LT24Rd_n),
        .LT24DataOut (LT24DataOut),
        .LT24DataOe  (LT24DataOe),
        .LT24DataIn  (LT24DataIn)
    );

    always #5 clock = ~clock;

    function automatic logic [16:0] exp_word(input int i, input int x, input int y);
        case (i)
            0:       return {1'b0, 16'h002A};
            1, 3:    return {1'b1, 16'(x / 256)};
            2, 4:    return {1'b1, 16'(x % 256)};
            5:       return {1'b0, 16'h002B};
            6, 8:    return {1'b1, 16'(y / 256)};
            7, 9:    return {1'b1, 16'(y % 256)};
            default: return {1'b0, 16'h002E};
        endcase
    endfunction

    function automatic logic [15:0] exp_pixel(input int rg, input int b);
        int r8, g8, b8;
        r8 = rg / 256;
        g8 = rg % 256;
        b8 = b / 256;
        return 16'((r8 / 8) * 2048 + (g8 / 4) * 32 + b8 / 8);
    endfunction

    // Bus monitor and pad model, observed just after each rising edge.
    always @(posedge clock) begin
        cyc++;
        #1;
        checks++;
        if (LT24DataOe && !LT24Rd_n) begin
            errors++;
            $display("FAIL oe_vs_rd: DataOe=1 with Rd_n=0 at cycle %0d", cyc);
        end
        if (reset) begin
            wr_run = 0;
            rd_run = 0;
        end else begin
            if (!LT24Wr_n) begin
                wr_run++;
                words.push_back({LT24RS, LT24DataOut});
                checks++;
                if ({LT24DataOe, LT24CS_n} !== 2'b10) begin
                    errors++;
                    $display("FAIL write_ctrl: {oe,cs_n}=%b expected 10 at cycle %0d", {LT24DataOe, LT24CS_n}, cyc);
                end
            end else if (wr_run > 0) begin
                checks++;
                if (wr_run != 1) begin
                    errors++;
                    $display("FAIL wr_low_len: got %0d expected 1", wr_run);
                end
                wr_run = 0;
            end
            if (!LT24Rd_n) begin
                if (prev_rd_n) begin
                    LT24DataIn = pad[rd_slot % 3];
                    rd_slot++;
                end
                rd_run++;
            end else if (rd_run > 0) begin
                checks++;
                if (rd_run != RD_LOW) begin
                    errors++;
                    $display("FAIL rd_low_len: got %0d expected %0d", rd_run, RD_LOW);
                end
                rd_run = 0;
            end
        end
        if (prev_cs_n && !LT24CS_n) cs_starts++;
        if (pixelValid) begin
            pv_cnt++;
            pv_cyc = cyc;
            checks++;
            if (LT24CS_n !== 1'b1) begin
                errors++;
                $display("FAIL cs_at_valid: CS_n=%b expected 1", LT24CS_n);
            end
        end
        if (error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        prev_cs_n = LT24CS_n;
        prev_rd_n = LT24Rd_n;
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({ready, pixelValid, error, LT24CS_n, LT24Wr_n, LT24Rd_n, LT24RS, LT24DataOe} !== 8'b1001_1110) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 10011110",
                     {ready, pixelValid, error, LT24CS_n, LT24Wr_n, LT24Rd_n, LT24RS, LT24DataOe});
        end
        checks++;
        if (pixelData !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pixel: got %h expected 0000", pixelData);
        end
        checks++;
        if (LT24DataOut !== 16'h0000) begin
            errors++;
            $display("FAIL reset_dataout: got %h expected 0000", LT24DataOut);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", ready);
        end
    endtask

    task automatic run_txn(input int x, input int y, input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input string tag);
        int acc, t0, n;
        logic [15:0] px;
        pad[0] = d0;
        pad[1] = d1;
        pad[2] = d2;
        rd_slot = 0;
        words.delete();
        t0 = pv_cnt;
        n = 0;
        while (!ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        read = 1'b1;
        xAddr = 8'(x);
        yAddr = 9'(y);
        acc = cyc;
        @(negedge clock);
        read = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_drop: got %b expected 0", tag, ready);
        end
        n = 0;
        while (pv_cnt == t0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (pv_cnt != t0 + 1) begin
            errors++;
            $display("FAIL %s valid_count: got %0d expected %0d", tag, pv_cnt - t0, 1);
        end else begin
            checks++;
            if (pv_cyc - acc != LATENCY) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", tag, pv_cyc - acc, LATENCY);
            end
            px = exp_pixel(int'(d1), int'(d2));
            checks++;
            if (pixelData !== px) begin
                errors++;
                $display("FAIL %s pixel: got %h expected %h", tag, pixelData, px);
            end
            checks++;
            if (words.size() != 11) begin
                errors++;
                $display("FAIL %s word_count: got %0d expected 11", tag, words.size());
            end else begin
                for (int i = 0; i < 11; i++) begin
                    checks++;
                    if (words[i] !== exp_word(i, x, y)) begin
                        errors++;
                        $display("FAIL %s word%0d: got %h expected %h", tag, i, words[i], exp_word(i, x, y));
                    end
                end
            end
        end
        @(negedge clock);
        checks++;
        if (ready !== 1'b1 || pixelValid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: ready/valid=%b%b expected 10", tag, ready, pixelValid);
        end
    endtask

    task automatic test_directed();
        run_txn(10, 300, 16'h1234, 16'hF8FC, 16'hF800, "x10_y300");
        checks++;
        if (pixelData !== 16'hFFFF) begin
            errors++;
            $display("FAIL x10_y300_white: got %h expected ffff", pixelData);
        end
    endtask

    task automatic test_corner();
        run_txn(239, 319, 16'h0000, 16'h0000, 16'h0000, "x239_y319");
        run_txn(0, 0, 16'hFFFF, 16'h0700, 16'h0000, "x0_y0");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_txn(int'($urandom_range(0, 239)), int'($urandom_range(0, 319)), 16'($urandom),
                    16'($urandom), 16'($urandom), "random");
        end
    endtask

    task automatic test_error();
        int xs[3] = '{240, 0, 255};
        int ys[3] = '{0, 320, 511};
        int acc, c0, e0;
        for (int k = 0; k < 3; k++) begin
            words.delete();
            c0 = cs_starts;
            e0 = err_cnt;
            read = 1'b1;
            xAddr = 8'(xs[k]);
            yAddr = 9'(ys[k]);
            acc = cyc;
            @(negedge clock);
            read = 1'b0;
            checks++;
            if ({error, ready, LT24CS_n} !== 3'b111) begin
                errors++;
                $display("FAIL err_pulse%0d: {error,ready,cs_n}=%b expected 111", k, {error, ready, LT24CS_n});
            end
            @(negedge clock);
            checks++;
            if (error !== 1'b0) begin
                errors++;
                $display("FAIL err_width%0d: got %b expected 0", k, error);
            end
            repeat (5) @(negedge clock);
            checks++;
            if (err_cnt - e0 != 1 || err_cyc - acc != 1) begin
                errors++;
                $display("FAIL err_timing%0d: pulses=%0d delay=%0d expected 1 and 1", k, err_cnt - e0, err_cyc - acc);
            end
            checks++;
            if (words.size() != 0 || cs_starts != c0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL err_no_bus%0d: writes=%0d cs=%0d ready=%b expected 0 0 1",
                         k, words.size(), cs_starts - c0, ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc, t0, n;
        pad[0] = 16'hAAAA;
        pad[1] = 16'h5555;
        pad[2] = 16'h3333;
        rd_slot = 0;
        t0 = pv_cnt;
        read = 1'b1;
        xAddr = 8'd100;
        yAddr = 9'd200;
        acc = cyc;
        @(negedge clock);
        read = 1'b0;
        n = 0;
        while (cyc < acc + 40 && n < 100) begin
            @(negedge clock);
            n++;
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({LT24CS_n, LT24Wr_n, LT24Rd_n, LT24DataOe, ready, pixelValid} !== 6'b111010) begin
            errors++;
            $display("FAIL mid_reset: {cs,wr,rd,oe,ready,valid}=%b expected 111010",
                     {LT24CS_n, LT24Wr_n, LT24Rd_n, LT24DataOe, ready, pixelValid});
        end
        reset = 1'b0;
        repeat (100) @(negedge clock);
        checks++;
        if (pv_cnt != t0) begin
            errors++;
            $display("FAIL mid_reset_novalid: got %0d pulses expected 0", pv_cnt - t0);
        end
        run_txn(17, 42, 16'h0001, 16'hC0A0, 16'h7F00, "after_reset");
    endtask

    task automatic test_back_to_back();
        int accs[$];
        int t0, c0, n;
        logic [15:0] px;
        pad[0] = 16'h0F0F;
        pad[1] = 16'h8844;
        pad[2] = 16'h9900;
        rd_slot = 0;
        words.delete();
        t0 = pv_cnt;
        c0 = cs_starts;
        read = 1'b1;
        xAddr = 8'd5;
        yAddr = 9'd260;
        n = 0;
        while (accs.size() < 3 && n < 400) begin
            if (ready) accs.push_back(cyc);
            if (accs.size() < 3) @(negedge clock);
            n++;
        end
        @(negedge clock);
        read = 1'b0;
        n = 0;
        while (pv_cnt < t0 + 3 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (accs.size() != 3 || pv_cnt - t0 != 3 || cs_starts - c0 != 3) begin
            errors++;
            $display("FAIL b2b_counts: accepts=%0d valids=%0d cs=%0d expected 3 3 3",
                     accs.size(), pv_cnt - t0, cs_starts - c0);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (accs[i] - accs[i-1] != LATENCY + 1) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, accs[i] - accs[i-1], LATENCY + 1);
                end
            end
        end
        checks++;
        if (words.size() != 33) begin
            errors++;
            $display("FAIL b2b_words: got %0d expected 33", words.size());
        end
        px = exp_pixel(int'(pad[1]), int'(pad[2]));
        checks++;
        if (pixelData !== px) begin
            errors++;
            $display("FAIL b2b_pixel: got %h expected %h", pixelData, px);
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_error();
        test_corner();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
